instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Instruction fetch stage of the 19-bit CPU. Accepts fetch addresses from the program counter through a valid/ready handshake and issues single-outstanding reads to instruction memory. It returns instruction words, tagged with their fetch address, to the decoder through a 2-entry queue. A flush input, driven on branch or jump, discards queued and in-flight instructions.

## Interface
- WORD_SIZE, 19, width of addresses and instruction words
- QUEUE_DEPTH, 2, instruction queue entries (power of two, ≥2)

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- pc_addr  in  WORD_SIZE  fetch address from program counter
- pc_valid  in  1  pc_addr is valid
- pc_ready  out  1  address accepted this cycle; the PC advances on pc_valid & pc_ready
- mem_req  out  1  read request to instruction memory
- mem_addr  out  WORD_SIZE  read address
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  WORD_SIZE  instruction word
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decoder consumes the head this cycle
- instr_data  out  WORD_SIZE  instruction at queue head
- instr_pc  out  WORD_SIZE  fetch address of the head instruction
- FLUSH  in  1  discard all queued and in-flight instructions

## Operation
- FSM states:
  - IDLE: no request outstanding
  - REQ: mem_req held high until granted
  - WAIT: granted, awaiting response
  - DISCARD: granted, response is to be dropped
- pc_ready (combinational) = (state==IDLE) & (count < QUEUE_DEPTH) & !FLUSH & !RST.
- IDLE, pc_valid & pc_ready: latch pc_addr into mem_addr; go to REQ.
- REQ: mem_req=1, mem_addr stable.
  - mem_gnt: go to WAIT.
  - FLUSH (with or without mem_gnt): go to IDLE. An ungranted request is withdrawn. A request granted in the same cycle as FLUSH goes to DISCARD instead.
- WAIT:
  - mem_rvalid & !FLUSH: push {mem_addr, mem_rdata}; go to IDLE.
  - mem_rvalid & FLUSH: drop the data; go to IDLE.
  - FLUSH alone: go to DISCARD.
- DISCARD: on mem_rvalid, drop the data; go to IDLE. FLUSH has no further effect.
- mem_rvalid in IDLE or REQ is a protocol violation and is ignored.
- Queue:
  - FIFO with count 0..QUEUE_DEPTH; instr_valid = (count != 0).
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Push is never attempted when full: issue requires count < QUEUE_DEPTH and at most one read is in flight.
  - Pointers wrap modulo QUEUE_DEPTH.
- FLUSH:
  - Clears the queue (count=0, pointers=0) at the same edge.
  - A same-cycle pop or push is overridden.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_addr=0, queue empty, instr_valid=0, instr_data=0, instr_pc=0; pc_ready=0 while RST high.
- Reset mid-operation: any in-flight read is abandoned. Instruction memory shares RST and issues no stale response.
- Best-case latency, with an immediate grant and rvalid one cycle after grant:
  - cycle 0: pc handshake
  - cycle 1: mem_req=1, mem_gnt=1
  - cycle 2: mem_rvalid
  - cycle 3: instr_valid=1
- Peak throughput: one instruction per 3 cycles. The next pc handshake may occur in the cycle after the push.
- instr_data and instr_pc hold stable while instr_valid & !instr_ready.
- After FLUSH at edge N: instr_valid=0 from N+1, and pc_ready is 0 during the FLUSH cycle. A fresh handshake is possible at N+1 if the state is IDLE; otherwise it waits until DISCARD completes.

## Test plan
- Single fetch: pc_addr=0x00010, mem_gnt immediate, rvalid 1 cycle later, rdata=0x5A5A5 -> instr_valid at cycle 3 with instr_data=0x5A5A5, instr_pc=0x00010.
- Backpressure: instr_ready=0, stream addresses 0,1,2 -> two entries queue, pc_ready stays 0. On release, 0 then 1 pop in order, then 2 is fetched.
- Grant stall: mem_gnt low 4 cycles -> mem_req and mem_addr stable for 5 cycles; exactly one response enqueued.
- Flush in WAIT: FLUSH after grant of 0x00020, rvalid arrives 3 cycles later -> data dropped, instr_valid never set for 0x00020, next fetch of 0x00100 delivered correctly.
- Simultaneous: FLUSH coincident with mem_rvalid and a queue pop, queue holding 1 entry -> queue empty next cycle, no enqueue, state IDLE.
- Reset mid-WAIT: assert RST asynchronously between edges -> mem_req=0, instr_valid=0 immediately; after release a normal fetch succeeds.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: one outstanding instruction-memory read at a time, with
// results delivered to the decoder through a small address-tagged FIFO that FLUSH clears.
module instruction_fetch_unit #(
    parameter int unsigned WORD_SIZE   = 19,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WORD_SIZE-1:0] pc_addr,
    input  logic                 pc_valid,
    output logic                 pc_ready,
    output logic                 mem_req,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [WORD_SIZE-1:0] instr_data,
    output logic [WORD_SIZE-1:0] instr_pc,
    input  logic                 FLUSH
);

    localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] data_q [QUEUE_DEPTH];
    logic [WORD_SIZE-1:0] pc_q   [QUEUE_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 push;
    logic                 pop;

    // Issue only with room for the reply; at most one read is ever in flight.
    assign pc_ready    = (state_q == IDLE) && (count_q < FULL_CNT) && !FLUSH && !RST;
    assign mem_req     = (state_q == REQ);
    assign mem_addr    = addr_q;
    assign instr_valid = (count_q != '0);
    assign instr_data  = data_q[rd_ptr_q];
    assign instr_pc    = pc_q[rd_ptr_q];
    assign pop         = instr_valid && instr_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pc_valid && pc_ready) begin
                    addr_d  = pc_addr;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A grant coinciding with FLUSH still owes a response that must be dropped.
                if (FLUSH) begin
                    if (mem_gnt) state_d = DISCARD;
                    else         state_d = IDLE;
                end else if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    push    = !FLUSH;
                    state_d = IDLE;
                end else if (FLUSH) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (mem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= mem_rdata;
            pc_q[wr_ptr_q]   <= addr_q;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, hand-built corner sequences,
// and randomized traffic checked against a transaction-level model of the fetch stage.
module tb_instruction_fetch_unit;

    localparam int W = 19;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] pc_addr = '0;
    logic         pc_valid = 1'b0;
    logic         pc_ready;
    logic         mem_req;
    logic [W-1:0] mem_addr;
    logic         mem_gnt = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [W-1:0] mem_rdata = '0;
    logic         instr_valid;
    logic         instr_ready = 1'b0;
    logic [W-1:0] instr_data;
    logic [W-1:0] instr_pc;
    logic         FLUSH = 1'b0;

    instruction_fetch_unit #(.WORD_SIZE(19), .QUEUE_DEPTH(2)) dut (
        .CLK(CLK), .RST(RST),
        .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc),
        .FLUSH(FLUSH)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%05h expected 0x%05h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one fetch transaction plus a queue of delivered instructions.
    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] data;
    } ent_t;

    bit           m_busy;     // an address was accepted and its read is not finished
    bit           m_granted;  // memory has taken that read
    bit           m_keep;     // its reply is still wanted
    logic [W-1:0] m_addr;
    ent_t         mq[$];

    task automatic model_reset();
        m_busy = 0; m_granted = 0; m_keep = 0; m_addr = '0;
        mq.delete();
    endtask

    function automatic bit m_ready(input bit fl);
        return !m_busy && (mq.size() < 2) && !fl;
    endfunction

    task automatic drive(input bit pv, input logic [W-1:0] pa, input bit g, input bit rv,
                         input logic [W-1:0] rd, input bit fl, input bit ir);
        pc_valid = pv; pc_addr = pa; mem_gnt = g; mem_rvalid = rv;
        mem_rdata = rd; FLUSH = fl; instr_ready = ir;
    endtask

    task automatic step(input bit pv, input logic [W-1:0] pa, input bit g, input bit rv,
                        input logic [W-1:0] rd, input bit fl, input bit ir);
        ent_t e;
        bit   do_push;
        bit   do_pop;
        @(negedge CLK);
        drive(pv, pa, g, rv, rd, fl, ir);
        #1;
        check1("pc_ready", pc_ready, m_ready(fl));
        check1("mem_req", mem_req, m_busy && !m_granted);
        check("mem_addr", mem_addr, m_addr);
        check1("instr_valid", instr_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("instr_data", instr_data, mq[0].data);
            check("instr_pc", instr_pc, mq[0].pc);
        end
        do_pop  = (mq.size() != 0) && ir;
        do_push = m_busy && m_granted && m_keep && rv && !fl;
        e.pc    = m_addr;
        e.data  = rd;
        if (!m_busy) begin
            if (pv && m_ready(fl)) begin
                m_busy = 1; m_granted = 0; m_keep = 1; m_addr = pa;
            end
        end else if (!m_granted) begin
            if (g) begin
                m_granted = 1;
                if (fl) m_keep = 0;
            end else if (fl) begin
                m_busy = 0;
            end
        end else begin
            if (rv)      m_busy = 0;
            else if (fl) m_keep = 0;
        end
        if (fl) mq.delete();
        else begin
            if (do_pop) mq.delete(0);
            if (do_push) mq.push_back(e);
        end
    endtask

    // Memory that grants/responds when enabled and only when the protocol allows.
    task automatic mstep(input bit pv, input logic [W-1:0] pa, input bit fl, input bit ir,
                         input bit gnt_en, input bit rv_en, input bit stray);
        bit g;
        bit rv;
        g  = m_busy && !m_granted && gnt_en;
        rv = (m_busy && m_granted) ? rv_en : stray;
        step(pv, pa, g, rv, m_addr ^ 19'h2AAAA, fl, ir);
    endtask

    task automatic do_reset();
        drive(0, '0, 0, 0, '0, 0, 0);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit pv; logic [W-1:0] pa; bit g; bit rv; logic [W-1:0] rd; bit fl; bit ir;
        bit e_rdy; bit e_req; logic [W-1:0] e_addr; bit e_iv; logic [W-1:0] e_data; logic [W-1:0] e_pc;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input bit pv, input logic [W-1:0] pa, input bit g, input bit rv,
                               input logic [W-1:0] rd, input bit fl, input bit ir,
                               input bit e_rdy, input bit e_req, input logic [W-1:0] e_addr,
                               input bit e_iv, input logic [W-1:0] e_data, input logic [W-1:0] e_pc);
        vec_t r;
        r.pv = pv; r.pa = pa; r.g = g; r.rv = rv; r.rd = rd; r.fl = fl; r.ir = ir;
        r.e_rdy = e_rdy; r.e_req = e_req; r.e_addr = e_addr;
        r.e_iv = e_iv; r.e_data = e_data; r.e_pc = e_pc;
        return r;
    endfunction

    initial begin
        logic [W-1:0] got[$];
        int           a;
        int           nreq;
        int           npop;

        // Single fetch with best-case latency
        vt.push_back(v(1, 'h10, 0, 0, 0,        0, 0,  1, 0, 'h0,   0, 0, 0));
        vt.push_back(v(0, 0,    1, 0, 0,        0, 0,  0, 1, 'h10,  0, 0, 0));
        vt.push_back(v(0, 0,    0, 1, 'h5A5A5,  0, 0,  0, 0, 'h10,  0, 0, 0));
        vt.push_back(v(0, 0,    0, 0, 0,        0, 0,  1, 0, 'h10,  1, 'h5A5A5, 'h10));
        vt.push_back(v(0, 0,    0, 0, 0,        0, 1,  1, 0, 'h10,  1, 'h5A5A5, 'h10));
        vt.push_back(v(0, 0,    0, 0, 0,        0, 0,  1, 0, 'h10,  0, 0, 0));
        // FLUSH while waiting: late reply dropped, next fetch clean
        vt.push_back(v(1, 'h20, 0, 0, 0,        0, 0,  1, 0, 'h10,  0, 0, 0));
        vt.push_back(v(0, 0,    1, 0, 0,        0, 0,  0, 1, 'h20,  0, 0, 0));
        vt.push_back(v(0, 0,    0, 0, 0,        1, 0,  0, 0, 'h20,  0, 0, 0));
        vt.push_back(v(0, 0,    0, 0, 0,        0, 0,  0, 0, 'h20,  0, 0, 0));
        vt.push_back(v(0, 0,    0, 0, 0,        0, 0,  0, 0, 'h20,  0, 0, 0));
        vt.push_back(v(0, 0,    0, 1, 'h07777,  0, 0,  0, 0, 'h20,  0, 0, 0));
        vt.push_back(v(1, 'h100,0, 0, 0,        0, 0,  1, 0, 'h20,  0, 0, 0));
        vt.push_back(v(0, 0,    1, 0, 0,        0, 0,  0, 1, 'h100, 0, 0, 0));
        vt.push_back(v(0, 0,    0, 1, 'h12345,  0, 0,  0, 0, 'h100, 0, 0, 0));
        vt.push_back(v(0, 0,    0, 0, 0,        0, 1,  1, 0, 'h100, 1, 'h12345, 'h100));
        vt.push_back(v(0, 0,    0, 0, 0,        0, 0,  1, 0, 'h100, 0, 0, 0));
        // FLUSH with rvalid and pop while one entry is queued
        vt.push_back(v(1, 'h200,0, 0, 0,        0, 0,  1, 0, 'h100, 0, 0, 0));
        vt.push_back(v(0, 0,    1, 0, 0,        0, 0,  0, 1, 'h200, 0, 0, 0));
        vt.push_back(v(0, 0,    0, 1, 'h0AAAA,  0, 0,  0, 0, 'h200, 0, 0, 0));
        vt.push_back(v(1, 'h201,0, 0, 0,        0, 0,  1, 0, 'h200, 1, 'h0AAAA, 'h200));
        vt.push_back(v(0, 0,    1, 0, 0,        0, 0,  0, 1, 'h201, 1, 'h0AAAA, 'h200));
        vt.push_back(v(0, 0,    0, 1, 'h3BBBB,  1, 1,  0, 0, 'h201, 1, 'h0AAAA, 'h200));
        vt.push_back(v(0, 0,    0, 0, 0,        0, 0,  1, 0, 'h201, 0, 0, 0));
        // FLUSH coinciding with grant: reply owed and dropped
        vt.push_back(v(1, 'h300,0, 0, 0,        0, 0,  1, 0, 'h201, 0, 0, 0));
        vt.push_back(v(0, 0,    1, 0, 0,        1, 0,  0, 1, 'h300, 0, 0, 0));
        vt.push_back(v(0, 0,    0, 0, 0,        0, 0,  0, 0, 'h300, 0, 0, 0));
        vt.push_back(v(0, 0,    0, 1, 'h11111,  0, 0,  0, 0, 'h300, 0, 0, 0));
        vt.push_back(v(0, 0,    0, 0, 0,        0, 0,  1, 0, 'h300, 0, 0, 0));
        // FLUSH withdraws an ungranted request; stray rvalid in IDLE ignored
        vt.push_back(v(1, 'h400,0, 0, 0,        0, 0,  1, 0, 'h300, 0, 0, 0));
        vt.push_back(v(0, 0,    0, 0, 0,        1, 0,  0, 1, 'h400, 0, 0, 0));
        vt.push_back(v(0, 0,    0, 1, 'h06666,  0, 0,  1, 0, 'h400, 0, 0, 0));
        vt.push_back(v(0, 0,    0, 0, 0,        0, 0,  1, 0, 'h400, 0, 0, 0));

        // Reset state, with pc_valid asserted to show pc_ready gated by RST
        drive(1, 'h1234, 0, 0, '0, 0, 0);
        @(negedge CLK);
        #1;
        check1("rst_pc_ready", pc_ready, 1'b0);
        check1("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check1("rst_instr_valid", instr_valid, 1'b0);
        check("rst_instr_data", instr_data, '0);
        check("rst_instr_pc", instr_pc, '0);
        do_reset();

        foreach (vt[i]) begin
            @(negedge CLK);
            drive(vt[i].pv, vt[i].pa, vt[i].g, vt[i].rv, vt[i].rd, vt[i].fl, vt[i].ir);
            #1;
            check1($sformatf("v%0d_pc_ready", i), pc_ready, vt[i].e_rdy);
            check1($sformatf("v%0d_mem_req", i), mem_req, vt[i].e_req);
            check($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].e_addr);
            check1($sformatf("v%0d_instr_valid", i), instr_valid, vt[i].e_iv);
            if (vt[i].e_iv) begin
                check($sformatf("v%0d_instr_data", i), instr_data, vt[i].e_data);
                check($sformatf("v%0d_instr_pc", i), instr_pc, vt[i].e_pc);
            end
        end

        // Backpressure: stream 0,1,2 with the decoder stalled
        do_reset();
        a = 0;
        for (int c = 0; c < 12; c++) begin
            bit acc;
            acc = (a <= 2) && m_ready(0);
            mstep(a <= 2, W'(a), 0, 0, 1, 1, 0);
            if (acc) a++;
        end
        check("bp_accepted", W'(a), W'(2));
        check1("bp_full_ready", pc_ready, 1'b0);
        check("bp_head_pc", instr_pc, '0);
        for (int c = 0; c < 12; c++) begin
            bit acc;
            acc = (a <= 2) && m_ready(0);
            mstep(a <= 2, W'(a), 0, 1, 1, 1, 0);
            if (acc) a++;
            if (instr_valid && instr_ready) got.push_back(instr_pc);
        end
        check("bp_pops", W'(got.size()), W'(3));
        for (int k = 0; k < 3 && k < got.size(); k++)
            check($sformatf("bp_order%0d", k), got[k], W'(k));

        // Grant stall: request held for 5 cycles, one reply enqueued
        for (int c = 0; c < 3; c++) mstep(0, '0, 0, 1, 1, 1, 0);
        nreq = 0;
        npop = 0;
        mstep(1, 'h50, 0, 1, 1, 1, 0);
        for (int c = 0; c < 4; c++) begin
            mstep(0, '0, 0, 1, 0, 1, 0);
            if (mem_req && mem_addr == 'h50) nreq++;
        end
        for (int c = 0; c < 6; c++) begin
            mstep(0, '0, 0, 1, 1, 1, 0);
            if (mem_req && mem_addr == 'h50) nreq++;
            if (instr_valid && instr_ready && instr_pc == 'h50) npop++;
        end
        check("gs_req_cycles", W'(nreq), W'(5));
        check("gs_pops", W'(npop), W'(1));

        // Asynchronous reset while a read is in flight and an entry is queued
        mstep(1, 'h60, 0, 0, 1, 1, 0);
        mstep(0, '0, 0, 0, 1, 0, 0);
        mstep(0, '0, 0, 0, 1, 1, 0);
        mstep(1, 'h61, 0, 0, 1, 1, 0);
        mstep(0, '0, 0, 0, 1, 0, 0);
        @(negedge CLK);
        drive(0, '0, 0, 0, '0, 0, 0);
        #1;
        check1("rw_pre_valid", instr_valid, 1'b1);
        #1;
        RST = 1'b1;
        #1;
        check1("rw_mem_req", mem_req, 1'b0);
        check("rw_mem_addr", mem_addr, '0);
        check1("rw_instr_valid", instr_valid, 1'b0);
        check1("rw_pc_ready", pc_ready, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        npop = 0;
        mstep(1, 'h70, 0, 1, 1, 1, 0);
        for (int c = 0; c < 5; c++) begin
            mstep(0, '0, 0, 1, 1, 1, 0);
            if (instr_valid && instr_ready && instr_pc == 'h70 && instr_data == ('h70 ^ 19'h2AAAA)) npop++;
        end
        check("rw_refetch", W'(npop), W'(1));

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            mstep($urandom_range(0, 99) < 70, W'($urandom),
                  $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
